// File: rtl/cdc_pkg.sv
// Shared types and default constants for the domain-B edge debouncer.
// Used by cdc_edge_debouncer, its bus interface and cdc_sat_counter.
package cdc_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_PEND = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_PEND = 2'd3
  } edge_state_t;

  localparam int CDC_STABLE_CYCLES_DEF = 4;
  localparam int CDC_CNT_WIDTH_DEF     = 8;

endpackage

// File: rtl/cdc_edge_debouncer_if.sv
// Bus between the debouncer and its consumer in domain B.
// glitch_count exists only when CDC_EDGE_GLITCH_MON_EN is defined.
interface cdc_edge_debouncer_if
  import cdc_pkg::*;
#(
  parameter int CNT_WIDTH = CDC_CNT_WIDTH_DEF
) ();

  logic                 sync_in;
  logic                 count_clr;
  logic                 level_out;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [CNT_WIDTH-1:0] edge_count;
`ifdef CDC_EDGE_GLITCH_MON_EN
  logic [CNT_WIDTH-1:0] glitch_count;

  modport master (
    output sync_in, count_clr,
    input  level_out, rise_pulse, fall_pulse, edge_count, glitch_count
  );

  modport slave (
    input  sync_in, count_clr,
    output level_out, rise_pulse, fall_pulse, edge_count, glitch_count
  );
`else
  modport master (
    output sync_in, count_clr,
    input  level_out, rise_pulse, fall_pulse, edge_count
  );

  modport slave (
    input  sync_in, count_clr,
    output level_out, rise_pulse, fall_pulse, edge_count
  );
`endif

endinterface

// File: rtl/cdc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module cdc_sat_counter
  import cdc_pkg::*;
#(
  parameter int WIDTH = CDC_CNT_WIDTH_DEF
) (
  input  logic             clk_B,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk_B) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cdc_edge_debouncer.sv
// Stable-sample filter on the synchronized level with edge pulses and counters.
// Optional macro CDC_EDGE_GLITCH_MON_EN adds the rejected-transition counter.
module cdc_edge_debouncer
  import cdc_pkg::*;
#(
  parameter int STABLE_CYCLES = CDC_STABLE_CYCLES_DEF,
  parameter int CNT_WIDTH     = CDC_CNT_WIDTH_DEF
) (
  input  logic                 clk_B,
  input  logic                 reset,
  cdc_edge_debouncer_if.slave  bus
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  edge_state_t   state;
  edge_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          last_sample;
  logic          rise_next;
  logic          fall_next;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic          edge_acc;

  always_ff @(posedge clk_B) begin
    if (reset) begin
      state   <= S_LOW;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      level_q <= (state_next == S_HIGH) || (state_next == S_FALL_PEND);
      rise_q  <= rise_next;
      fall_q  <= fall_next;
    end
  end

  // The pending count includes the sample that opened the transition.
  assign last_sample = (32'(cnt) + 32'd1) == 32'(STABLE_CYCLES);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      S_LOW: begin
        if (bus.sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_next = S_HIGH;
            rise_next  = 1'b1;
          end else begin
            state_next = S_RISE_PEND;
            cnt_next   = CNT_ONE;
          end
        end
      end
      S_RISE_PEND: begin
        if (bus.sync_in) begin
          if (last_sample) begin
            state_next = S_HIGH;
            cnt_next   = '0;
            rise_next  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          state_next = S_LOW;
          cnt_next   = '0;
        end
      end
      S_HIGH: begin
        if (!bus.sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_next = S_LOW;
            fall_next  = 1'b1;
          end else begin
            state_next = S_FALL_PEND;
            cnt_next   = CNT_ONE;
          end
        end
      end
      S_FALL_PEND: begin
        if (!bus.sync_in) begin
          if (last_sample) begin
            state_next = S_LOW;
            cnt_next   = '0;
            fall_next  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign edge_acc       = rise_next | fall_next;
  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

  cdc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_edge_cnt (
    .clk_B (clk_B),
    .reset (reset),
    .clr   (bus.count_clr),
    .inc   (edge_acc),
    .count (bus.edge_count)
  );

`ifdef CDC_EDGE_GLITCH_MON_EN
  logic glitch;

  // A pending transition that sees the old level again is abandoned.
  assign glitch = ((state == S_RISE_PEND) && !bus.sync_in) ||
                  ((state == S_FALL_PEND) &&  bus.sync_in);

  cdc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_glitch_cnt (
    .clk_B (clk_B),
    .reset (reset),
    .clr   (bus.count_clr),
    .inc   (glitch),
    .count (bus.glitch_count)
  );
`endif

endmodule

// File: tb/tb_cdc_edge_debouncer.sv
// Self-checking bench: three debouncer configurations share one stimulus stream
// and are compared against a run-length reference model.
module tb_cdc_edge_debouncer;
  import cdc_pkg::*;

  logic clk_B = 1'b0;
  always #5 clk_B = ~clk_B;

  logic reset_drv;
  logic sync_drv;
  logic clr_drv;

  int checks   = 0;
  int failures = 0;

  // dut0: default config, dut1: 2-bit counters, dut2: single-sample filter
  cdc_edge_debouncer_if #(.CNT_WIDTH(8)) bus0 ();
  cdc_edge_debouncer_if #(.CNT_WIDTH(2)) bus1 ();
  cdc_edge_debouncer_if #(.CNT_WIDTH(8)) bus2 ();

  assign bus0.sync_in   = sync_drv;
  assign bus0.count_clr = clr_drv;
  assign bus1.sync_in   = sync_drv;
  assign bus1.count_clr = clr_drv;
  assign bus2.sync_in   = sync_drv;
  assign bus2.count_clr = clr_drv;

  cdc_edge_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut0 (
    .clk_B (clk_B), .reset (reset_drv), .bus (bus0.slave));
  cdc_edge_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) dut1 (
    .clk_B (clk_B), .reset (reset_drv), .bus (bus1.slave));
  cdc_edge_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) dut2 (
    .clk_B (clk_B), .reset (reset_drv), .bus (bus2.slave));

  logic       obs_level [3];
  logic       obs_rise  [3];
  logic       obs_fall  [3];
  logic [7:0] obs_edge  [3];

  assign obs_level[0] = bus0.level_out;
  assign obs_level[1] = bus1.level_out;
  assign obs_level[2] = bus2.level_out;
  assign obs_rise[0]  = bus0.rise_pulse;
  assign obs_rise[1]  = bus1.rise_pulse;
  assign obs_rise[2]  = bus2.rise_pulse;
  assign obs_fall[0]  = bus0.fall_pulse;
  assign obs_fall[1]  = bus1.fall_pulse;
  assign obs_fall[2]  = bus2.fall_pulse;
  assign obs_edge[0]  = bus0.edge_count;
  assign obs_edge[1]  = {6'd0, bus1.edge_count};
  assign obs_edge[2]  = bus2.edge_count;

`ifdef CDC_EDGE_GLITCH_MON_EN
  logic [7:0] obs_glitch [3];
  assign obs_glitch[0] = bus0.glitch_count;
  assign obs_glitch[1] = {6'd0, bus1.glitch_count};
  assign obs_glitch[2] = bus2.glitch_count;
`endif

  // Reference model: accepted level plus length of the current run of differing samples.
  int   sc_of  [3] = '{4, 4, 1};
  int   max_of [3] = '{255, 3, 255};
  logic m_level  [3];
  logic m_rise   [3];
  logic m_fall   [3];
  int   m_run    [3];
  int   m_edge   [3];
  int   m_glitch [3];

  task automatic tick();
    @(posedge clk_B);
    for (int d = 0; d < 3; d++) begin
      logic acc;
      logic glitch_ev;
      acc       = 1'b0;
      glitch_ev = 1'b0;
      m_rise[d] = 1'b0;
      m_fall[d] = 1'b0;
      if (reset_drv) begin
        m_level[d]  = 1'b0;
        m_run[d]    = 0;
        m_edge[d]   = 0;
        m_glitch[d] = 0;
      end else begin
        if (sync_drv != m_level[d]) begin
          m_run[d]++;
          if (m_run[d] == sc_of[d]) begin
            m_level[d] = sync_drv;
            m_run[d]   = 0;
            m_rise[d]  = sync_drv;
            m_fall[d]  = !sync_drv;
            acc        = 1'b1;
          end
        end else begin
          glitch_ev = (m_run[d] != 0);
          m_run[d]  = 0;
        end
        if (clr_drv) begin
          m_edge[d]   = 0;
          m_glitch[d] = 0;
        end else begin
          if (acc && m_edge[d] < max_of[d]) m_edge[d]++;
          if (glitch_ev && m_glitch[d] < max_of[d]) m_glitch[d]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_drv = 1'b1;
    sync_drv  = 1'b0;
    clr_drv   = 1'b0;
    repeat (2) tick();
    reset_drv = 1'b0;
  endtask

  task automatic test_reset();
    reset_drv = 1'b1;
    sync_drv  = 1'b1;
    clr_drv   = 1'b0;
    repeat (3) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({obs_level[d], obs_rise[d], obs_fall[d]} !== 3'b000 || obs_edge[d] !== 8'd0) begin
          failures++;
          $display("[TB] FAIL reset_outputs dut%0d got level=%b rise=%b fall=%b edge=%0d expected all 0",
                   d, obs_level[d], obs_rise[d], obs_fall[d], obs_edge[d]);
        end
`ifdef CDC_EDGE_GLITCH_MON_EN
        checks++;
        if (obs_glitch[d] !== 8'd0) begin
          failures++;
          $display("[TB] FAIL reset_glitch dut%0d got=%0d expected=0", d, obs_glitch[d]);
        end
`endif
      end
    end
    reset_drv = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic exp_l;
      tick();
      exp_l = (i == 4);
      checks++;
      if (obs_level[0] !== exp_l) begin
        failures++;
        $display("[TB] FAIL reset_release_latency edge%0d got=%b expected=%b", i, obs_level[0], exp_l);
      end
      checks++;
      if (obs_level[2] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_release_fast edge%0d got=%b expected=1", i, obs_level[2]);
      end
    end
  endtask

  task automatic test_clean_step();
    do_reset();
    sync_drv = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (obs_rise[0] !== (i == 4) || obs_fall[0] !== 1'b0 || obs_level[0] !== (i >= 4)) begin
        failures++;
        $display("[TB] FAIL step_rise cyc%0d got rise=%b fall=%b level=%b expected rise=%b fall=0 level=%b",
                 i, obs_rise[0], obs_fall[0], obs_level[0], (i == 4), (i >= 4));
      end
    end
    checks++;
    if (obs_edge[0] !== 8'd1) begin
      failures++;
      $display("[TB] FAIL step_edge_after_rise got=%0d expected=1", obs_edge[0]);
    end
    sync_drv = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (obs_fall[0] !== (i == 4) || obs_rise[0] !== 1'b0 || obs_level[0] !== (i < 4)) begin
        failures++;
        $display("[TB] FAIL step_fall cyc%0d got fall=%b rise=%b level=%b expected fall=%b rise=0 level=%b",
                 i, obs_fall[0], obs_rise[0], obs_level[0], (i == 4), (i < 4));
      end
    end
    checks++;
    if (obs_edge[0] !== 8'd2) begin
      failures++;
      $display("[TB] FAIL step_edge_after_fall got=%0d expected=2", obs_edge[0]);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      sync_drv = (i <= 3);
      tick();
      checks++;
      if ({obs_level[0], obs_rise[0], obs_fall[0]} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL glitch_quiet cyc%0d got level=%b rise=%b fall=%b expected 0 0 0",
                 i, obs_level[0], obs_rise[0], obs_fall[0]);
      end
    end
    checks++;
    if (obs_edge[0] !== 8'd0) begin
      failures++;
      $display("[TB] FAIL glitch_edge_count got=%0d expected=0", obs_edge[0]);
    end
`ifdef CDC_EDGE_GLITCH_MON_EN
    checks++;
    if (obs_glitch[0] !== 8'd1) begin
      failures++;
      $display("[TB] FAIL glitch_count got=%0d expected=1", obs_glitch[0]);
    end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      sync_drv = e[0];
      repeat (5) tick();
    end
    checks++;
    if (obs_edge[1] !== 8'd3) begin
      failures++;
      $display("[TB] FAIL sat_hold got=%0d expected=3", obs_edge[1]);
    end
    checks++;
    if (obs_edge[0] !== 8'd6) begin
      failures++;
      $display("[TB] FAIL sat_wide_count got=%0d expected=6", obs_edge[0]);
    end
    sync_drv = 1'b1;
    repeat (3) tick();
    clr_drv = 1'b1;
    tick();
    clr_drv = 1'b0;
    checks++;
    if (obs_edge[1] !== 8'd0 || obs_edge[0] !== 8'd0) begin
      failures++;
      $display("[TB] FAIL sat_clear_wins got narrow=%0d wide=%0d expected 0 0", obs_edge[1], obs_edge[0]);
    end
    checks++;
    if (obs_level[0] !== 1'b1 || obs_rise[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_seventh_edge got level=%b rise=%b expected 1 1", obs_level[0], obs_rise[0]);
    end
  endtask

  task automatic test_reset_mid_pending();
    do_reset();
    sync_drv = 1'b1;
    repeat (2) tick();
    reset_drv = 1'b1;
    tick();
    reset_drv = 1'b0;
    sync_drv  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if ({obs_level[0], obs_rise[0], obs_fall[0]} !== 3'b000 || obs_edge[0] !== 8'd0) begin
        failures++;
        $display("[TB] FAIL midpend cyc%0d got level=%b rise=%b fall=%b edge=%0d expected all 0",
                 i, obs_level[0], obs_rise[0], obs_fall[0], obs_edge[0]);
      end
`ifdef CDC_EDGE_GLITCH_MON_EN
      checks++;
      if (obs_glitch[0] !== 8'd0) begin
        failures++;
        $display("[TB] FAIL midpend_glitch cyc%0d got=%0d expected=0", i, obs_glitch[0]);
      end
`endif
    end
  endtask

  task automatic test_stable_one();
    logic prev;
    logic exp_r;
    logic exp_f;
    do_reset();
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sync_drv = ((i / 2) % 2 == 0);
      tick();
      exp_r = sync_drv && !prev;
      exp_f = !sync_drv && prev;
      prev  = sync_drv;
      checks++;
      if (obs_level[2] !== sync_drv || obs_rise[2] !== exp_r || obs_fall[2] !== exp_f) begin
        failures++;
        $display("[TB] FAIL fast_follow cyc%0d got level=%b rise=%b fall=%b expected level=%b rise=%b fall=%b",
                 i, obs_level[2], obs_rise[2], obs_fall[2], sync_drv, exp_r, exp_f);
      end
    end
    checks++;
    if (obs_edge[2] !== 8'd8) begin
      failures++;
      $display("[TB] FAIL fast_edge_count got=%0d expected=8", obs_edge[2]);
    end
  endtask

  task automatic test_random();
    int hold_left;
    do_reset();
    hold_left = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold_left == 0) begin
        sync_drv  = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 6);
      end
      hold_left--;
      clr_drv   = ($urandom_range(0, 24) == 0);
      reset_drv = ($urandom_range(0, 149) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs_level[d] !== m_level[d] || obs_rise[d] !== m_rise[d] || obs_fall[d] !== m_fall[d]) begin
          failures++;
          $display("[TB] FAIL rand_outputs dut%0d cyc%0d got level=%b rise=%b fall=%b expected %b %b %b",
                   d, c, obs_level[d], obs_rise[d], obs_fall[d], m_level[d], m_rise[d], m_fall[d]);
        end
        checks++;
        if (obs_edge[d] !== 8'(m_edge[d])) begin
          failures++;
          $display("[TB] FAIL rand_edge_count dut%0d cyc%0d got=%0d expected=%0d", d, c, obs_edge[d], m_edge[d]);
        end
`ifdef CDC_EDGE_GLITCH_MON_EN
        checks++;
        if (obs_glitch[d] !== 8'(m_glitch[d])) begin
          failures++;
          $display("[TB] FAIL rand_glitch_count dut%0d cyc%0d got=%0d expected=%0d", d, c, obs_glitch[d], m_glitch[d]);
        end
`endif
        checks++;
        if (obs_rise[d] === 1'b1 && obs_fall[d] === 1'b1) begin
          failures++;
          $display("[TB] FAIL rand_pulse_exclusive dut%0d cyc%0d got rise=1 fall=1 expected not both", d, c);
        end
      end
    end
    reset_drv = 1'b0;
    clr_drv   = 1'b0;
  endtask

  initial begin
    reset_drv = 1'b1;
    sync_drv  = 1'b0;
    clr_drv   = 1'b0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_saturation();
    test_reset_mid_pending();
    test_stable_one();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
